multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Control FSM that sequences the single-cycle decode/execute datapath as a multi-cycle machine: FETCH -> DECODE -> EXEC -> MEM -> WB.
- Handshakes with instruction memory and data memory, and drives register-file, PC and instruction-register write enables.
- Counts retired instructions.
- Halts on SYSTEM opcodes, illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: max consecutive not-ready cycles tolerated in FETCH/MEM before a bus error; 0 disables the watchdog.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  permission to start/continue fetching.
- opcode  input  7  instr[6:0] of the instruction register (valid from DECODE onward).
- imemReady  input  1  instruction memory data valid this cycle.
- dmemReady  input  1  data memory access complete this cycle.
- imemReq  output  1  instruction fetch request.
- irWriteEnable  output  1  latch fetched instruction.
- dmemReq  output  1  data memory request.
- dmemWrite  output  1  data memory access is a store.
- regWriteEnable  output  1  register-file write strobe.
- pcWriteEnable  output  1  PC update strobe; the datapath selects pc+4 or the target.
- state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- halted  output  1  sticky, SYSTEM opcode reached.
- illegalInstr  output  1  sticky, unknown opcode decoded.
- busError  output  1  sticky, watchdog expired.
- instret  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: state=IDLE; instret=0; all flags=0; all strobes=0; wait counter=0.
- Strobes (combinational from state and ready):
  - imemReq = FETCH.
  - irWriteEnable = FETCH & imemReady.
  - dmemReq = MEM.
  - dmemWrite = MEM & opcode==0100011.
  - regWriteEnable = WB.
  - pcWriteEnable = retire cycle.
- IDLE: go to FETCH when run=1.
- FETCH: hold while imemReady=0; on imemReady go to DECODE.
- DECODE, 1 cycle, by opcode:
  - 1110011 -> HALT, set halted.
  - Recognised opcodes -> EXEC: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Anything else -> HALT, set illegalInstr.
- EXEC, 1 cycle:
  - load/store -> MEM.
  - branch (1100011) is a retire cycle.
  - all other recognised opcodes -> WB.
- MEM: hold while dmemReady=0. On dmemReady: store is a retire cycle; load -> WB.
- WB: 1 cycle, retire cycle.
- Retire cycle:
  - pcWriteEnable=1; instret increments (wraps modulo 2^CNT_WIDTH).
  - Next state is FETCH if run=1, else IDLE.
  - Exactly one retire per instruction.
- Cycle count per instruction (zero wait states):
  - branch: 3.
  - ALU/LUI/AUIPC/JAL/JALR: 4.
  - store: 4.
  - load: 5.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and increments each cycle the relevant ready is 0.
  - If ready=0 while counter==MEM_TIMEOUT-1: -> HALT, set busError.
  - Ready in that same cycle takes priority (no error).
- HALT: all strobes 0; leave only via reset. Flags and instret hold.
- run is sampled only in IDLE and at retire; deasserting it mid-instruction does not abort the instruction.
- Reset mid-instruction: returns to IDLE next edge; any strobe asserted in that cycle still occurs (reset is synchronous).
- Simultaneous ready on both memories: only the one matching the current state is used.

Test Plan:
- Reset, run=1, ADDI (opcode 0010011), imemReady=1 always -> states 1,2,3,5,1; irWriteEnable in cycle 1; regWriteEnable and pcWriteEnable in cycle 4; instret=1.
- LW with dmemReady low 3 cycles -> MEM held 4 cycles, dmemWrite=0, then WB; total 8 cycles; instret increments once.
- SW then BEQ back-to-back -> store retires from MEM with dmemWrite=1 and no regWriteEnable; branch retires from EXEC after 3 cycles; instret=2.
- Opcode 0000000 -> HALT after DECODE; illegalInstr=1; strobes stay 0 for 20 further cycles despite run=1.
- MEM_TIMEOUT=16, imemReady held 0 -> busError=1 and state=6 after the 16th FETCH cycle; repeat with ready on the 16th cycle -> no error, DECODE.
- ECALL (1110011) -> halted=1; run=0 at an ALU retire -> IDLE; assert reset mid-WB -> IDLE, instret=0.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// Drives memory handshakes and write strobes, counts retired instructions, halts on faults.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 imemReady,
  input  logic                 dmemReady,
  output logic                 imemReq,
  output logic                 irWriteEnable,
  output logic                 dmemReq,
  output logic                 dmemWrite,
  output logic                 regWriteEnable,
  output logic                 pcWriteEnable,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegalInstr,
  output logic                 busError,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The counter only has to reach MEM_TIMEOUT-1 before the watchdog fires.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              known_op;
  logic              timeout;
  logic              retire;
  logic              set_halted;
  logic              set_illegal;
  logic              set_bus;

  assign state    = cur;
  assign known_op = opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                   OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt            = cur;
    retire         = 1'b0;
    set_halted     = 1'b0;
    set_illegal    = 1'b0;
    set_bus        = 1'b0;
    imemReq        = 1'b0;
    irWriteEnable  = 1'b0;
    dmemReq        = 1'b0;
    dmemWrite      = 1'b0;
    regWriteEnable = 1'b0;
    pcWriteEnable  = 1'b0;
    case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          irWriteEnable = 1'b1;
          nxt           = S_DECODE;
        end else if (timeout) begin
          set_bus = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_SYSTEM) begin
          set_halted = 1'b1;
          nxt        = S_HALT;
        end else if (known_op) begin
          nxt = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt         = S_HALT;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) nxt = S_MEM;
        else if (opcode == OP_BRANCH)                retire = 1'b1;
        else                                         nxt = S_WB;
      end
      S_MEM: begin
        dmemReq   = 1'b1;
        dmemWrite = (opcode == OP_STORE);
        if (dmemReady) begin
          if (opcode == OP_STORE) retire = 1'b1;
          else                    nxt = S_WB;
        end else if (timeout) begin
          set_bus = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_WB: begin
        regWriteEnable = 1'b1;
        retire         = 1'b1;
      end
      default: nxt = cur;
    endcase
    // Every retire path funnels through here so run is sampled in one place.
    if (retire) begin
      pcWriteEnable = 1'b1;
      nxt           = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur          <= S_IDLE;
      wait_cnt     <= '0;
      halted       <= 1'b0;
      illegalInstr <= 1'b0;
      busError     <= 1'b0;
      instret      <= '0;
    end else begin
      cur          <= nxt;
      halted       <= halted | set_halted;
      illegalInstr <= illegalInstr | set_illegal;
      busError     <= busError | set_bus;
      if (retire) instret <= instret + CNT_WIDTH'(1);
      // A state change is the only way into FETCH or MEM, so it restarts the watchdog.
      if (nxt != cur)
        wait_cnt <= '0;
      else if ((cur == S_FETCH && !imemReady) || (cur == S_MEM && !dmemReady))
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
// Per-cycle stimulus and expected outputs are queued, then replayed and compared.
module tb_multicycle_control;

  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] ECALL = 7'b1110011;
  localparam logic [6:0] BAD   = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        imemReady = 1'b0;
  logic        dmemReady = 1'b0;
  logic        imemReq, irWriteEnable, dmemReq, dmemWrite, regWriteEnable, pcWriteEnable;
  logic [2:0]  state;
  logic        halted, illegalInstr, busError;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        chk;
    logic        run;
    logic        im;
    logic        dm;
    logic [6:0]  op;
    logic [11:0] exp;
    logic [31:0] ret;
  } cyc_t;

  cyc_t q[$];

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .irWriteEnable(irWriteEnable), .dmemReq(dmemReq),
    .dmemWrite(dmemWrite), .regWriteEnable(regWriteEnable), .pcWriteEnable(pcWriteEnable),
    .state(state), .halted(halted), .illegalInstr(illegalInstr), .busError(busError),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // strobes: imemReq irWriteEnable dmemReq dmemWrite regWriteEnable pcWriteEnable
  // flags:   halted illegalInstr busError
  function automatic logic [11:0] ev(input logic [2:0] st, input logic [5:0] sb, input logic [2:0] fl);
    return {st, sb, fl};
  endfunction

  function automatic logic [11:0] obs();
    return {state, imemReq, irWriteEnable, dmemReq, dmemWrite, regWriteEnable, pcWriteEnable,
            halted, illegalInstr, busError};
  endfunction

  function automatic void push(input logic rst, input logic chk, input logic r, input logic im,
                               input logic dm, input logic [6:0] op, input logic [11:0] exp,
                               input logic [31:0] ret);
    cyc_t c;
    c.rst = rst; c.chk = chk; c.run = r; c.im = im; c.dm = dm; c.op = op; c.exp = exp; c.ret = ret;
    q.push_back(c);
  endfunction

  // Unchecked reset cycle followed by one checked IDLE cycle with run raised.
  function automatic void push_start(input logic [6:0] op);
    push(1, 0, 0, 0, 0, op, ev(0, 0, 0), 0);
    push(0, 1, 1, 1, 0, op, ev(0, 0, 0), 0);
  endfunction

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; imemReady = 1'b1; dmemReady = 1'b1; opcode = ADDI;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (obs() !== ev(0, 0, 0)) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs(), ev(0, 0, 0));
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL reset_instret got %0d want 0", instret);
    end
  endtask

  task automatic test_alu();
    cyc_t c;
    int n = 0;
    push_start(ADDI);
    push(0, 1, 1, 1, 0, ADDI, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(2, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(3, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(5, 6'b000011, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(1, 6'b110000, 0), 1);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL alu cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL alu_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  task automatic test_load_wait();
    cyc_t c;
    int n = 0;
    push_start(LW);
    push(0, 1, 1, 1, 1, LW, ev(1, 6'b110000, 0), 0);
    push(0, 1, 0, 1, 1, LW, ev(2, 6'b000000, 0), 0);
    push(0, 1, 0, 1, 1, LW, ev(3, 6'b000000, 0), 0);
    for (int i = 0; i < 3; i++) push(0, 1, 0, 1, 0, LW, ev(4, 6'b001000, 0), 0);
    push(0, 1, 0, 0, 1, LW, ev(4, 6'b001000, 0), 0);
    push(0, 1, 0, 0, 0, LW, ev(5, 6'b000011, 0), 0);
    push(0, 1, 0, 0, 0, LW, ev(0, 6'b000000, 0), 1);
    push(0, 1, 0, 1, 1, LW, ev(0, 6'b000000, 0), 1);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL load cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL load_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    int n = 0;
    push_start(SW);
    push(0, 1, 1, 1, 0, SW,  ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, SW,  ev(2, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 0, SW,  ev(3, 6'b000000, 0), 0);
    push(0, 1, 1, 0, 1, SW,  ev(4, 6'b001101, 0), 0);
    push(0, 1, 1, 1, 0, BEQ, ev(1, 6'b110000, 0), 1);
    push(0, 1, 1, 1, 0, BEQ, ev(2, 6'b000000, 0), 1);
    push(0, 1, 0, 1, 0, BEQ, ev(3, 6'b000001, 0), 1);
    push(0, 1, 0, 1, 0, BEQ, ev(0, 6'b000000, 0), 2);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL b2b cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL b2b_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    cyc_t c;
    int n = 0;
    push_start(BAD);
    push(0, 1, 1, 1, 0, BAD, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, BAD, ev(2, 6'b000000, 0), 0);
    for (int i = 0; i < 21; i++) push(0, 1, 1, 1, 1, BAD, ev(6, 6'b000000, 3'b010), 0);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL illegal cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL illegal_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  task automatic test_watchdog();
    cyc_t c;
    int n = 0;
    push_start(ADDI);
    for (int i = 0; i < 16; i++) push(0, 1, 1, 0, 1, ADDI, ev(1, 6'b100000, 0), 0);
    push(0, 1, 1, 1, 1, ADDI, ev(6, 6'b000000, 3'b001), 0);
    push_start(ADDI);
    for (int i = 0; i < 15; i++) push(0, 1, 1, 0, 1, ADDI, ev(1, 6'b100000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(2, 6'b000000, 0), 0);
    push_start(LW);
    push(0, 1, 1, 1, 0, LW, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, LW, ev(2, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 0, LW, ev(3, 6'b000000, 0), 0);
    for (int i = 0; i < 16; i++) push(0, 1, 1, 1, 0, LW, ev(4, 6'b001000, 0), 0);
    push(0, 1, 1, 1, 1, LW, ev(6, 6'b000000, 3'b001), 0);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL watchdog cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL watchdog_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  task automatic test_halt_run_reset();
    cyc_t c;
    int n = 0;
    push_start(ECALL);
    push(0, 1, 1, 1, 0, ECALL, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, ECALL, ev(2, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 1, ECALL, ev(6, 6'b000000, 3'b100), 0);
    push(0, 1, 1, 1, 1, ECALL, ev(6, 6'b000000, 3'b100), 0);
    push_start(ADDI);
    push(0, 1, 1, 1, 0, ADDI, ev(1, 6'b110000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(2, 6'b000000, 0), 0);
    push(0, 1, 1, 1, 0, ADDI, ev(3, 6'b000000, 0), 0);
    push(0, 1, 0, 1, 0, ADDI, ev(5, 6'b000011, 0), 0);
    push(0, 1, 0, 1, 0, ADDI, ev(0, 6'b000000, 0), 1);
    push(0, 1, 1, 1, 0, ADDI, ev(0, 6'b000000, 0), 1);
    push(0, 1, 1, 1, 0, ADDI, ev(1, 6'b110000, 0), 1);
    push(0, 1, 1, 1, 0, ADDI, ev(2, 6'b000000, 0), 1);
    push(0, 1, 1, 1, 0, ADDI, ev(3, 6'b000000, 0), 1);
    push(1, 1, 1, 1, 0, ADDI, ev(5, 6'b000011, 0), 1);
    push(0, 1, 0, 1, 0, ADDI, ev(0, 6'b000000, 0), 0);
    while (q.size() != 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset = c.rst; run = c.run; imemReady = c.im; dmemReady = c.dm; opcode = c.op;
      #1;
      if (c.chk) begin
        checks++;
        if (obs() !== c.exp) begin errors++; $display("FAIL halt_run_reset cyc %0d got %b want %b", n, obs(), c.exp); end
        checks++;
        if (instret !== c.ret) begin errors++; $display("FAIL halt_run_reset_instret cyc %0d got %0d want %0d", n, instret, c.ret); end
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_watchdog();
    test_halt_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
